// File: rtl/sub12_serial.sv
// Bit-serial subtractor: d = x - y - bin, one SLICE-bit group per clock.
// LSB group first; borrow ripples between groups through a register.
module sub12_serial #(
    parameter int WIDTH = 12,
    parameter int SLICE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic                   borrow;
    logic [WIDTH-1:0]       x_r;
    logic [WIDTH-1:0]       y_r;
    logic [SLICE:0]         diff;
    logic [WIDTH+SLICE-1:0] d_next;
    logic                   last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == CW'(NSLICE - 1));

    // Slice subtract on the low group of the shifting operand copies;
    // the extra top bit of the difference is the slice borrow.
    always_comb begin
        diff   = {1'b0, x_r[SLICE-1:0]}
               - {1'b0, y_r[SLICE-1:0]}
               - {{SLICE{1'b0}}, borrow};
        d_next = {diff[SLICE-1:0], d};
    end

    // Control FSM and datapath registers; results shift in from the top
    // so slice 0 lands at the bottom after NSLICE steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            borrow <= 1'b0;
            x_r    <= '0;
            y_r    <= '0;
            d      <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r    <= x;
                        y_r    <= y;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    d      <= d_next[WIDTH+SLICE-1:SLICE];
                    borrow <= diff[SLICE];
                    x_r    <= x_r >> SLICE;
                    y_r    <= y_r >> SLICE;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        bout  <= diff[SLICE];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub12_serial.sv
// Bench for sub12_serial: vector table, corner sequences, random ops.
// Scoreboard queue is filled on accept and drained on output handshake.
module tb_sub12_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] x;
    logic [11:0] y;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] d;
    logic        bout;

    int total = 0;
    int bad = 0;
    int n_acc = 0;
    int n_out = 0;

    logic [11:0] exp_d_in;
    logic        exp_b_in;
    logic [12:0] sb[$];

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        bin;
        logic [11:0] ed;
        logic        eb;
    } vec_t;

    vec_t vecs[11];

    sub12_serial #(.WIDTH(12), .SLICE(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x(x),
        .y(y),
        .bin(bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d(d),
        .bout(bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back({exp_b_in, exp_d_in});
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [12:0] e;
                    e = sb.pop_front();
                    chk("d", 32'(d), 32'(e[11:0]));
                    chk("bout", 32'(bout), 32'(e[12]));
                end
            end
        end
    end

    task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                          input logic c, input logic [11:0] ed,
                          input logic eb, input int stall);
        int n;
        x        = a;
        y        = b;
        bin      = c;
        exp_d_in = ed;
        exp_b_in = eb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        x   = 12'($urandom);
        y   = 12'($urandom);
        bin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (!out_valid) chk("out_timeout", 32'd0, 32'd1);
        out_ready = 1'b0;
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [12:0] model(input logic [11:0] a,
                                          input logic [11:0] b,
                                          input logic c);
        return {1'b0, a} - {1'b0, b} - 13'(c);
    endfunction

    initial begin
        vecs[0]  = '{12'h800, 12'h123, 1'b0, 12'h6DD, 1'b0};
        vecs[1]  = '{12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1};
        vecs[2]  = '{12'h555, 12'h555, 1'b1, 12'hFFF, 1'b1};
        vecs[3]  = '{12'h555, 12'h555, 1'b0, 12'h000, 1'b0};
        vecs[4]  = '{12'hFFF, 12'h000, 1'b1, 12'hFFE, 1'b0};
        vecs[5]  = '{12'h000, 12'hFFF, 1'b0, 12'h001, 1'b1};
        vecs[6]  = '{12'h000, 12'h000, 1'b1, 12'hFFF, 1'b1};
        vecs[7]  = '{12'hABC, 12'h123, 1'b1, 12'h998, 1'b0};
        vecs[8]  = '{12'h100, 12'h0FF, 1'b1, 12'h000, 1'b0};
        vecs[9]  = '{12'h7FF, 12'h800, 1'b0, 12'hFFF, 1'b1};
        vecs[10] = '{12'h123, 12'h456, 1'b0, 12'hCCD, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        bin       = 1'b0;
        exp_d_in  = '0;
        exp_b_in  = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Latency: out_valid exactly 4 edges after the accepting edge.
        x = 12'h800; y = 12'h123; bin = 1'b0;
        exp_d_in = 12'h6DD; exp_b_in = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x = 12'hFFF; y = 12'hFFF; bin = 1'b1;
        chk("lat_e0", 32'(out_valid), 32'd0);
        chk("lat_busy", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("lat_early", 32'(out_valid), 32'd0);
        end
        tick();
        chk("lat_e4", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("back_idle", 32'(in_ready), 32'd1);
        chk("d_held_idle", 32'(d), 32'h6DD);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].bin,
                   vecs[i].ed, vecs[i].eb, i % 3);
        end

        // DONE stall: outputs hold, busy, in_valid pulses ignored.
        x = 12'h9A5; y = 12'h3C7; bin = 1'b0;
        exp_d_in = 12'h5DE; exp_b_in = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'(i % 2 == 0);
            x = 12'($urandom);
            y = 12'($urandom);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_d", 32'(d), 32'h5DE);
            chk("stall_bout", 32'(bout), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release", 32'(out_valid), 32'd0);

        // Reset after two CALC edges discards the op.
        x = 12'h321; y = 12'h123; bin = 1'b0;
        exp_d_in = 12'h1FE; exp_b_in = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_d", 32'(d), 32'd0);
        n_acc = 0;
        n_out = 0;
        run_op(12'h0F0, 12'h00F, 1'b0, 12'h0E1, 1'b0, 1);

        for (int i = 0; i < 1000; i++) begin
            logic [11:0] a;
            logic [11:0] b;
            logic        c;
            logic [12:0] r;
            a = 12'($urandom);
            b = 12'($urandom);
            c = 1'($urandom);
            r = model(a, b, c);
            run_op(a, b, c, r[11:0], r[12], $urandom_range(0, 3));
        end

        tick();
        chk("count_match", 32'(n_out), 32'(n_acc));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
